// File: rtl/mask_lfsr_gen.sv
// Galois-LFSR mask generator: emits bursts of random keep-masks over a valid/ready handshake.
// Optional MASK_BIAS_EN build ORs extra LFSR slices to raise the per-bit keep probability.
module mask_lfsr_gen #(
   parameter int                    WORD_SIZE    = 8,
   parameter int                    LFSR_WIDTH   = 32,
   parameter logic [LFSR_WIDTH-1:0] TAPS         = 32'h80200003,
   parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = 32'hACE1ACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  seed_load,
   input  logic [LFSR_WIDTH-1:0] seed_in,
   input  logic                  start,
   input  logic [15:0]           burst_len,
`ifdef MASK_BIAS_EN
   input  logic [1:0]            keep_bias,
`endif
   output logic                  mask_valid,
   input  logic                  mask_ready,
   output logic [WORD_SIZE-1:0]  random_mask,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           sample_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic [LFSR_WIDTH-1:0] lfsr_next;
   logic [LFSR_WIDTH-1:0] seed_eff;
   logic [15:0]           remaining;
   logic [WORD_SIZE-1:0]  mask_now;
   logic [WORD_SIZE-1:0]  mask_next;
   logic                  accept;

`ifdef MASK_BIAS_EN
   // Each extra OR-ed slice halves the chance of a bit being dropped.
   function automatic logic [WORD_SIZE-1:0] mask_of(input logic [LFSR_WIDTH-1:0] s,
                                                    input logic [1:0] kb);
      logic [WORD_SIZE-1:0] m;
      m = s[WORD_SIZE-1:0];
      for (int j = 1; j < 4; j++) begin
         if (j <= int'(kb)) begin
            m = m | s[j*WORD_SIZE +: WORD_SIZE];
         end
      end
      return m;
   endfunction

   always_comb begin
      mask_now  = mask_of(lfsr, keep_bias);
      mask_next = mask_of(lfsr_next, keep_bias);
   end
`else
   function automatic logic [WORD_SIZE-1:0] mask_of(input logic [LFSR_WIDTH-1:0] s);
      return s[WORD_SIZE-1:0];
   endfunction

   always_comb begin
      mask_now  = mask_of(lfsr);
      mask_next = mask_of(lfsr_next);
   end
`endif

   // An all-zero seed would lock the LFSR, so it is replaced by the default seed.
   always_comb begin
      lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
      seed_eff  = (seed_in == '0) ? SEED_DEFAULT : seed_in;
      accept    = mask_valid & mask_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr         <= SEED_DEFAULT;
         state        <= IDLE;
         mask_valid   <= 1'b0;
         random_mask  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sample_count <= 16'd0;
         remaining    <= 16'd0;
      end else if (seed_load) begin
         lfsr         <= seed_eff;
         state        <= IDLE;
         mask_valid   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sample_count <= 16'd0;
         remaining    <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (burst_len != 16'd0) begin
                     state       <= RUN;
                     remaining   <= burst_len;
                     random_mask <= mask_now;
                     mask_valid  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            // A stall simply skips this branch, so mask, LFSR and count all hold.
            RUN: begin
               if (accept) begin
                  lfsr         <= lfsr_next;
                  sample_count <= sample_count + 16'd1;
                  remaining    <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     mask_valid <= 1'b0;
                     state      <= DONE;
                     done       <= 1'b1;
                  end else begin
                     random_mask <= mask_next;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               mask_valid <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mask_lfsr_gen.sv
// Directed bench for mask_lfsr_gen: table-driven bursts plus hand-written stall, abort,
// zero-length and reset sequences; expected masks are hand-stepped LFSR values.
module tb_mask_lfsr_gen;

   logic        clk;
   logic        rst_n;
   logic        seed_load;
   logic [31:0] seed_in;
   logic        start;
   logic [15:0] burst_len;
`ifdef MASK_BIAS_EN
   logic [1:0]  keep_bias;
`endif
   logic        mask_valid;
   logic        mask_ready;
   logic [7:0]  random_mask;
   logic        busy;
   logic        done;
   logic [15:0] sample_count;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] seed;
      logic [15:0] len;
      logic [7:0]  m0;
      logic [7:0]  m1;
      logic [7:0]  m2;
   } vec_t;

   vec_t vecs [4];

   mask_lfsr_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seed_load    (seed_load),
      .seed_in      (seed_in),
      .start        (start),
      .burst_len    (burst_len),
`ifdef MASK_BIAS_EN
      .keep_bias    (keep_bias),
`endif
      .mask_valid   (mask_valid),
      .mask_ready   (mask_ready),
      .random_mask  (random_mask),
      .busy         (busy),
      .done         (done),
      .sample_count (sample_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic sl, input logic [31:0] sd, input logic st,
                                input logic [15:0] len, input logic rdy);
      seed_load  = sl;
      seed_in    = sd;
      start      = st;
      burst_len  = len;
      mask_ready = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pickMask(input vec_t v, input int k);
      return (k == 0) ? v.m0 : ((k == 1) ? v.m1 : v.m2);
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
`ifdef MASK_BIAS_EN
      keep_bias = 2'd0;
`endif
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b0);

      vecs[0] = '{seed: 32'h00000001, len: 16'd3, m0: 8'h01, m1: 8'h03, m2: 8'h02};
      vecs[1] = '{seed: 32'h00000000, len: 16'd2, m0: 8'hE1, m1: 8'h73, m2: 8'h00};
      vecs[2] = '{seed: 32'h00000002, len: 16'd3, m0: 8'h02, m1: 8'h01, m2: 8'h03};
      vecs[3] = '{seed: 32'h12345678, len: 16'd1, m0: 8'h78, m1: 8'h00, m2: 8'h00};

      #12;
      checkOutput("reset_valid", 32'(mask_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_count", 32'(sample_count), 32'd0);
      rst_n = 1'b1;
      step();

      // Table-driven bursts with the consumer always ready.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, vecs[i].seed, 1'b0, 16'd0, 1'b1);
         step();
         checkOutput($sformatf("v%0d_load_valid", i), 32'(mask_valid), 32'd0);
         checkOutput($sformatf("v%0d_load_count", i), 32'(sample_count), 32'd0);
         applyStimulus(1'b0, 32'h0, 1'b1, vecs[i].len, 1'b1);
         step();
         applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
         for (int k = 0; k < int'(vecs[i].len); k++) begin
            checkOutput($sformatf("v%0d_valid%0d", i, k), 32'(mask_valid), 32'd1);
            checkOutput($sformatf("v%0d_mask%0d", i, k), 32'(random_mask), 32'(pickMask(vecs[i], k)));
            checkOutput($sformatf("v%0d_busy%0d", i, k), 32'(busy), 32'd1);
            step();
         end
         checkOutput($sformatf("v%0d_done", i), 32'(done), 32'd1);
         checkOutput($sformatf("v%0d_end_valid", i), 32'(mask_valid), 32'd0);
         checkOutput($sformatf("v%0d_count", i), 32'(sample_count), 32'(vecs[i].len));
         step();
         checkOutput($sformatf("v%0d_done_drop", i), 32'(done), 32'd0);
         checkOutput($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      end

      // Backpressure: first mask held for four stalled cycles; a stray start is ignored.
      applyStimulus(1'b1, 32'h00000001, 1'b0, 16'd0, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd3, 1'b0);
      step();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 16'd9, 1'b0);
         checkOutput($sformatf("stall_valid%0d", k), 32'(mask_valid), 32'd1);
         checkOutput($sformatf("stall_mask%0d", k), 32'(random_mask), 32'h01);
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
      checkOutput("bp_mask0", 32'(random_mask), 32'h01);
      step();
      checkOutput("bp_mask1", 32'(random_mask), 32'h03);
      step();
      checkOutput("bp_mask2", 32'(random_mask), 32'h02);
      checkOutput("bp_count_mid", 32'(sample_count), 32'd2);
      step();
      checkOutput("bp_done", 32'(done), 32'd1);
      checkOutput("bp_count", 32'(sample_count), 32'd3);
      step();

      // Next burst continues from S3 without reseeding: masks 01, 03.
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd2, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
      checkOutput("cont_mask0", 32'(random_mask), 32'h01);
      step();
      checkOutput("cont_mask1", 32'(random_mask), 32'h03);
      step();
      checkOutput("cont_done", 32'(done), 32'd1);
      checkOutput("cont_count", 32'(sample_count), 32'd5);
      step();

      // Zero-length burst: done pulses next cycle with no mask.
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd0, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
      checkOutput("zero_done", 32'(done), 32'd1);
      checkOutput("zero_valid", 32'(mask_valid), 32'd0);
      checkOutput("zero_busy", 32'(busy), 32'd1);
      checkOutput("zero_count", 32'(sample_count), 32'd5);
      step();
      checkOutput("zero_done_drop", 32'(done), 32'd0);
      checkOutput("zero_idle", 32'(busy), 32'd0);

      // Abort: seed_load during the second mask of a 5-mask burst, while it is accepted.
      applyStimulus(1'b1, 32'h00000001, 1'b0, 16'd0, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd5, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
      step();
      checkOutput("abort_mask1", 32'(random_mask), 32'h03);
      applyStimulus(1'b1, 32'h00000001, 1'b0, 16'd0, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
      checkOutput("abort_valid", 32'(mask_valid), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_count", 32'(sample_count), 32'd0);
      step();
      checkOutput("abort_no_done", 32'(done), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd1, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b0);
      checkOutput("abort_reseed_mask", 32'(random_mask), 32'h01);

`ifdef MASK_BIAS_EN
      // Upper slices of seed 1 are zero, so full bias still yields 01.
      applyStimulus(1'b1, 32'h00000001, 1'b0, 16'd0, 1'b0);
      keep_bias = 2'd3;
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd2, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b0);
      checkOutput("bias_mask0", 32'(random_mask), 32'h01);
`endif

      // Asynchronous reset mid-burst while a mask is stalled and valid.
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_valid", 32'(mask_valid), 32'd0);
      checkOutput("areset_mask", 32'(random_mask), 32'd0);
      checkOutput("areset_busy", 32'(busy), 32'd0);
      checkOutput("areset_done", 32'(done), 32'd0);
      checkOutput("areset_count", 32'(sample_count), 32'd0);
      #10;
      rst_n = 1'b1;
      step();
`ifdef MASK_BIAS_EN
      keep_bias = 2'd0;
`endif
      applyStimulus(1'b0, 32'h0, 1'b1, 16'd1, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
      checkOutput("post_reset_mask", 32'(random_mask), 32'hE1);
      step();
      checkOutput("post_reset_done", 32'(done), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
